cs_packet_accumulator: RTL and testbench
========================================

# cs_packet_accumulator

Parametrised, handshaked per-lane packet adder for the compressive-sensing intra-prediction datapath. Each accepted packet holds LANES unsigned lanes of DATA_WIDTH bits. Lane 0 receives bias `in_b0`; every other lane receives bias `in_b`. Each packet is either emitted directly (add mode) or summed into a per-lane accumulator that is emitted on the last packet of a group (accumulate mode), with selectable wrap or saturating arithmetic. The block sits between the register bank and the measurement/packing stage, and is registered on both sides via a valid/ready handshake.

## Interface
Parameters:
- DATA_WIDTH, 16, width of one lane.
- LANES, 8, lanes per packet.
- SATURATE, 0, 0 = modulo-2^DATA_WIDTH wrap, 1 = clamp at 2^DATA_WIDTH-1.
- CNT_W, 8, width of the group beat counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_a  in  LANES*DATA_WIDTH  packet; lane i at bits [DATA_WIDTH*i +: DATA_WIDTH].
- in_b0  in  DATA_WIDTH  bias for lane 0.
- in_b  in  DATA_WIDTH  bias for lanes 1..LANES-1.
- in_mode  in  1  0 = add, 1 = accumulate.
- in_last  in  1  accumulate mode: closes the group; ignored in add mode.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_c  out  LANES*DATA_WIDTH  result packet, same lane layout as in_a.
- out_count  out  CNT_W  number of beats contributing to out_c.
- acc_open  out  1  accumulator holds a partial group.

## Operation
- Beat accepted when in_valid && in_ready.
- in_ready = !out_valid || out_ready. This is combinational from out_ready; there is no skid buffer.
- Lane term t_i = in_a_i + (i==0 ? in_b0 : in_b).
  - Computed at DATA_WIDTH+1 bits.
  - Wrap mode: low DATA_WIDTH bits.
  - Saturate mode: carry-out forces all-ones.
- Add mode (in_mode=0):
  - out_c_i <= t_i; out_count <= 1; out_valid <= 1.
  - Accumulator and group counter are untouched, so an open group survives interleaved add beats.
- Accumulate mode, in_last=0:
  - acc_i <= acc_i + t_i, with the same wrap/saturate rule applied again on the second add.
  - grp_cnt <= grp_cnt + 1, saturating at 2^CNT_W-1.
  - acc_open <= 1; no output is produced.
- Accumulate mode, in_last=1:
  - out_c_i <= acc_i + t_i; out_count <= grp_cnt + 1 (saturating); out_valid <= 1.
  - acc <= 0; grp_cnt <= 0; acc_open <= 0.
- A single beat with mode=1 and last=1 and no open group behaves like add mode, with out_count=1.
- Output register holds out_c/out_count stable while out_valid && !out_ready.
- No state machine beyond two implicit states, IDLE (acc_open=0) and OPEN (acc_open=1):
  - IDLE -> OPEN on an accumulate beat with last=0.
  - OPEN -> IDLE on an accumulate beat with last=1.

## Timing
- Latency: 1 cycle from acceptance to out_valid.
- Throughput: 1 beat/cycle while out_ready=1.
- Simultaneous output handshake and new input acceptance in the same cycle: the output register is reloaded and out_valid stays 1.
- A non-last accumulate beat accepted while out_valid=1 && out_ready=1: out_valid falls next cycle.
- Reset values (asynchronous on rst_n low, released synchronously to clk):
  - out_valid=0, out_c=0, out_count=0, acc_open=0.
  - Accumulator lanes 0, grp_cnt 0.
  - in_ready=1 immediately, since out_valid=0.
- Reset mid-group discards the partial accumulation; nothing is emitted.
- Inputs are sampled only on acceptance. in_a/in_b0/in_b/in_mode/in_last are don't-care otherwise.

## Test plan
Defaults: DATA_WIDTH=8, LANES=4, CNT_W=4.
- Add mode, wrap: in_a lanes {10,20,30,40}, b0=1, b=5 -> next cycle out_c {11,25,35,45}, out_count=1.
- Wrap vs saturate: lane0=250, b0=10. SATURATE=0 -> 4; SATURATE=1 -> 255. Other lanes 0 with b=0 -> 0.
- Accumulate group: three beats of lanes {1,2,3,4}, b0=1, b=0, last on the third -> single output {6,6,9,12}, out_count=3, acc_open 1 after the first beat and 0 after the output.
- Backpressure: hold out_ready=0 with a result pending -> in_ready=0, out_c stable for 5 cycles. Raise out_ready with a new beat present -> both transfer in the same cycle, back-to-back outputs with no bubble.
- Interleave: open a group (1 beat {1,1,1,1}, b=0, b0=0), send an add beat {7,7,7,7}, then close with {1,1,1,1} last -> outputs {7,7,7,7} count 1, then {2,2,2,2} count 2.
- Reset mid-group: two accumulate beats, assert rst_n=0 asynchronously between edges -> out_valid=0 and acc_open=0 immediately. After release, a last beat {3,3,3,3} yields {3,3,3,3} with count 1. Also check counter saturation: 20 beats -> out_count=15.

Source files
------------

// File: rtl/cs_packet_accumulator.sv
// Per-lane biased packet adder with optional group accumulation, wrap or saturate
// arithmetic, and a single registered valid/ready output stage.
module cs_packet_accumulator #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 8,
  parameter int SATURATE   = 0,
  parameter int CNT_W      = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0]       in_b0,
  input  logic [DATA_WIDTH-1:0]       in_b,
  input  logic                        in_mode,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*DATA_WIDTH-1:0] out_c,
  output logic [CNT_W-1:0]            out_count,
  output logic                        acc_open
);

  localparam int VW = LANES * DATA_WIDTH;

  typedef logic [DATA_WIDTH-1:0] lane_t;

  // One extra bit catches the carry; in saturate mode a carry clamps to all-ones.
  function automatic lane_t lane_add(input lane_t a, input lane_t b);
    logic [DATA_WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if ((SATURATE != 0) && sum[DATA_WIDTH]) return '1;
    return sum[DATA_WIDTH-1:0];
  endfunction

  logic             out_valid_q, out_valid_d;
  logic [VW-1:0]    out_c_q,     out_c_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic [VW-1:0]    acc_q,       acc_d;
  logic [CNT_W-1:0] grp_cnt_q,   grp_cnt_d;
  logic             acc_open_q,  acc_open_d;

  logic             accept;
  logic [CNT_W-1:0] grp_inc;
  logic [VW-1:0]    term_vec;
  logic [VW-1:0]    acc_sum;

  // No skid buffer: a full output register only frees up in the cycle it is drained.
  assign in_ready  = !out_valid_q || out_ready;
  assign out_valid = out_valid_q;
  assign out_c     = out_c_q;
  assign out_count = out_count_q;
  assign acc_open  = acc_open_q;

  always_comb begin
    accept   = in_valid && in_ready;
    grp_inc  = (grp_cnt_q == '1) ? grp_cnt_q : grp_cnt_q + CNT_W'(1);
    term_vec = '0;
    acc_sum  = '0;
    for (int i = 0; i < LANES; i++) begin
      term_vec[DATA_WIDTH*i +: DATA_WIDTH] =
        lane_add(in_a[DATA_WIDTH*i +: DATA_WIDTH], (i == 0) ? in_b0 : in_b);
      acc_sum[DATA_WIDTH*i +: DATA_WIDTH] =
        lane_add(acc_q[DATA_WIDTH*i +: DATA_WIDTH], term_vec[DATA_WIDTH*i +: DATA_WIDTH]);
    end

    // NOTE: every _d takes its _q as a default before any branch, so no latch is inferred.
    out_valid_d = out_valid_q && !out_ready;
    out_c_d     = out_c_q;
    out_count_d = out_count_q;
    acc_d       = acc_q;
    grp_cnt_d   = grp_cnt_q;
    acc_open_d  = acc_open_q;

    if (accept) begin
      if (!in_mode) begin
        out_c_d     = term_vec;
        out_count_d = CNT_W'(1);
        out_valid_d = 1'b1;
      end else if (!in_last) begin
        acc_d      = acc_sum;
        grp_cnt_d  = grp_inc;
        acc_open_d = 1'b1;
      end else begin
        // With no open group acc_q and grp_cnt_q are zero, so this degenerates to add mode.
        out_c_d     = acc_sum;
        out_count_d = grp_inc;
        out_valid_d = 1'b1;
        acc_d       = '0;
        grp_cnt_d   = '0;
        acc_open_d  = 1'b0;
      end
    end
  end

  // NOTE: the accumulator is a flop vector, not a RAM, so it is cleared by reset like
  // everything else; a mid-group reset therefore discards the partial sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_c_q     <= '0;
      out_count_q <= '0;
      acc_q       <= '0;
      grp_cnt_q   <= '0;
      acc_open_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_c_q     <= out_c_d;
      out_count_q <= out_count_d;
      acc_q       <= acc_d;
      grp_cnt_q   <= grp_cnt_d;
      acc_open_q  <= acc_open_d;
    end
  end

endmodule

// File: tb/tb_cs_packet_accumulator.sv
// Scoreboard bench: a wrap and a saturate instance share all inputs; a per-cycle
// monitor predicts and checks both, and each scenario task adds spot checks.
module tb_cs_packet_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_a = '0;
  logic [7:0]  in_b0 = '0;
  logic [7:0]  in_b = '0;
  logic        in_mode = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready_w, out_valid_w, acc_open_w;
  logic [31:0] out_c_w;
  logic [3:0]  out_count_w;
  logic        in_ready_s, out_valid_s, acc_open_s;
  logic [31:0] out_c_s;
  logic [3:0]  out_count_s;

  always #5 clk = ~clk;

  cs_packet_accumulator #(.DATA_WIDTH(8), .LANES(4), .SATURATE(0), .CNT_W(4)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_a(in_a), .in_b0(in_b0), .in_b(in_b), .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid_w), .out_ready(out_ready), .out_c(out_c_w),
    .out_count(out_count_w), .acc_open(acc_open_w)
  );

  cs_packet_accumulator #(.DATA_WIDTH(8), .LANES(4), .SATURATE(1), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_a(in_a), .in_b0(in_b0), .in_b(in_b), .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_c(out_c_s),
    .out_count(out_count_s), .acc_open(acc_open_s)
  );

  typedef struct {
    logic [31:0] c;
    logic [3:0]  cnt;
  } res_t;

  res_t       q_w[$];
  res_t       q_s[$];
  logic [7:0] acc_w[4];
  logic [7:0] acc_s[4];
  int         grp = 0;
  logic       exp_open = 1'b0;
  logic       exp_ov = 1'b0;
  int         n_vec = 0;
  int         n_err = 0;

  function automatic logic [7:0] madd(input logic [7:0] a, input logic [7:0] b, input bit sat);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (sat && s[8]) ? 8'hFF : s[7:0];
  endfunction

  // Reference model and scoreboard; advances one clock, returning 1 time unit after the edge.
  task automatic step();
    logic       exp_rdy;
    logic [7:0] bias, tw, ts, nw, ns;
    res_t       rw, rs;
    int         nc;
    @(negedge clk);
    if (!rst_n) begin
      q_w.delete(); q_s.delete();
      for (int i = 0; i < 4; i++) begin acc_w[i] = '0; acc_s[i] = '0; end
      grp = 0; exp_open = 1'b0; exp_ov = 1'b0;
    end else begin
      exp_rdy = !exp_ov || out_ready;
      n_vec++;
      if (in_ready_w !== exp_rdy || in_ready_s !== exp_rdy) begin
        n_err++;
        $display("FAIL in_ready: got %b/%b want %b", in_ready_w, in_ready_s, exp_rdy);
      end
      n_vec++;
      if (out_valid_w !== exp_ov || out_valid_s !== exp_ov) begin
        n_err++;
        $display("FAIL out_valid: got %b/%b want %b", out_valid_w, out_valid_s, exp_ov);
      end
      n_vec++;
      if (acc_open_w !== exp_open || acc_open_s !== exp_open) begin
        n_err++;
        $display("FAIL acc_open: got %b/%b want %b", acc_open_w, acc_open_s, exp_open);
      end
      if (exp_ov) begin
        n_vec++;
        if (q_w.size() == 0 || q_s.size() == 0) begin
          n_err++;
          $display("FAIL scoreboard: output expected but queue empty");
        end else if (out_c_w !== q_w[0].c || out_count_w !== q_w[0].cnt ||
                     out_c_s !== q_s[0].c || out_count_s !== q_s[0].cnt) begin
          n_err++;
          $display("FAIL result: got wrap %h/%0d sat %h/%0d want wrap %h/%0d sat %h/%0d",
                   out_c_w, out_count_w, out_c_s, out_count_s,
                   q_w[0].c, q_w[0].cnt, q_s[0].c, q_s[0].cnt);
        end
        if (out_ready && q_w.size() > 0 && q_s.size() > 0) begin
          void'(q_w.pop_front());
          void'(q_s.pop_front());
        end
      end
      exp_ov = exp_ov && !out_ready;
      if (in_valid && exp_rdy) begin
        rw.c = '0; rs.c = '0;
        nc = (grp + 1 > 15) ? 15 : grp + 1;
        for (int i = 0; i < 4; i++) begin
          bias = (i == 0) ? in_b0 : in_b;
          tw = madd(in_a[8*i +: 8], bias, 1'b0);
          ts = madd(in_a[8*i +: 8], bias, 1'b1);
          nw = madd(acc_w[i], tw, 1'b0);
          ns = madd(acc_s[i], ts, 1'b1);
          if (!in_mode) begin
            rw.c[8*i +: 8] = tw; rs.c[8*i +: 8] = ts;
          end else if (!in_last) begin
            acc_w[i] = nw; acc_s[i] = ns;
          end else begin
            rw.c[8*i +: 8] = nw; rs.c[8*i +: 8] = ns;
            acc_w[i] = '0; acc_s[i] = '0;
          end
        end
        if (!in_mode) begin
          rw.cnt = 4'd1; rs.cnt = 4'd1;
          q_w.push_back(rw); q_s.push_back(rs); exp_ov = 1'b1;
        end else if (!in_last) begin
          grp = nc; exp_open = 1'b1;
        end else begin
          rw.cnt = 4'(nc); rs.cnt = 4'(nc);
          q_w.push_back(rw); q_s.push_back(rs); exp_ov = 1'b1;
          grp = 0; exp_open = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] a, input logic [7:0] b0, input logic [7:0] b,
                      input logic mode, input logic last);
    in_a = a; in_b0 = b0; in_b = b; in_mode = mode; in_last = last; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid_w !== 1'b0 || out_c_w !== 32'h0 || out_count_w !== 4'd0 || acc_open_w !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got v=%b c=%h n=%0d open=%b want 0/0/0/0",
               out_valid_w, out_c_w, out_count_w, acc_open_w);
    end
    n_vec++;
    if (in_ready_w !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready_w);
    end
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_add_wrap();
    out_ready = 1'b1;
    beat(32'h281E140A, 8'd1, 8'd5, 1'b0, 1'b0);
    n_vec++;
    if (out_valid_w !== 1'b1 || out_c_w !== 32'h2D23190B || out_count_w !== 4'd1) begin
      n_err++;
      $display("FAIL add_wrap: got v=%b c=%h n=%0d want 1/2d23190b/1", out_valid_w, out_c_w, out_count_w);
    end
    step();
  endtask

  task automatic test_wrap_vs_sat();
    beat(32'h000000FA, 8'd10, 8'd0, 1'b0, 1'b0);
    n_vec++;
    if (out_c_w !== 32'h00000004) begin
      n_err++;
      $display("FAIL wrap_lane0: got %h want 00000004", out_c_w);
    end
    n_vec++;
    if (out_c_s !== 32'h000000FF) begin
      n_err++;
      $display("FAIL sat_lane0: got %h want 000000ff", out_c_s);
    end
    step();
  endtask

  task automatic test_accumulate();
    beat(32'h04030201, 8'd1, 8'd0, 1'b1, 1'b0);
    n_vec++;
    if (acc_open_w !== 1'b1 || out_valid_w !== 1'b0) begin
      n_err++;
      $display("FAIL acc_first: got open=%b v=%b want 1/0", acc_open_w, out_valid_w);
    end
    beat(32'h04030201, 8'd1, 8'd0, 1'b1, 1'b0);
    beat(32'h04030201, 8'd1, 8'd0, 1'b1, 1'b1);
    n_vec++;
    if (out_c_w !== 32'h0C090606 || out_count_w !== 4'd3 || acc_open_w !== 1'b0) begin
      n_err++;
      $display("FAIL acc_group: got c=%h n=%0d open=%b want 0c090606/3/0", out_c_w, out_count_w, acc_open_w);
    end
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    beat(32'h04030201, 8'd0, 8'd0, 1'b0, 1'b0);
    in_a = 32'h08070605; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_vec++;
      if (in_ready_w !== 1'b0 || out_c_w !== 32'h04030201) begin
        n_err++;
        $display("FAIL stall_%0d: got rdy=%b c=%h want 0/04030201", k, in_ready_w, out_c_w);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    n_vec++;
    if (out_valid_w !== 1'b1 || out_c_w !== 32'h08070605) begin
      n_err++;
      $display("FAIL same_cycle_xfer: got v=%b c=%h want 1/08070605", out_valid_w, out_c_w);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1; in_mode = 1'b0; in_b0 = 8'd0; in_b = 8'd0; in_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      in_a = 32'(k) * 32'h01010101;
      step();
      n_vec++;
      if (out_valid_w !== 1'b1 || out_c_w !== 32'(k) * 32'h01010101) begin
        n_err++;
        $display("FAIL b2b_%0d: got v=%b c=%h want 1/%h", k, out_valid_w, out_c_w, 32'(k) * 32'h01010101);
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_interleave();
    beat(32'h01010101, 8'd0, 8'd0, 1'b1, 1'b0);
    beat(32'h07070707, 8'd0, 8'd0, 1'b0, 1'b0);
    n_vec++;
    if (out_c_w !== 32'h07070707 || out_count_w !== 4'd1 || acc_open_w !== 1'b1) begin
      n_err++;
      $display("FAIL interleave_add: got c=%h n=%0d open=%b want 07070707/1/1", out_c_w, out_count_w, acc_open_w);
    end
    beat(32'h01010101, 8'd0, 8'd0, 1'b1, 1'b1);
    n_vec++;
    if (out_c_w !== 32'h02020202 || out_count_w !== 4'd2) begin
      n_err++;
      $display("FAIL interleave_close: got c=%h n=%0d want 02020202/2", out_c_w, out_count_w);
    end
    step();
  endtask

  task automatic test_reset_mid_group();
    beat(32'h05050505, 8'd0, 8'd0, 1'b1, 1'b0);
    beat(32'h05050505, 8'd0, 8'd0, 1'b1, 1'b0);
    n_vec++;
    if (acc_open_w !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_open: got %b want 1", acc_open_w);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid_w !== 1'b0 || acc_open_w !== 1'b0 || in_ready_w !== 1'b1) begin
      n_err++;
      $display("FAIL async_reset: got v=%b open=%b rdy=%b want 0/0/1", out_valid_w, acc_open_w, in_ready_w);
    end
    step();
    rst_n = 1'b1;
    step();
    beat(32'h03030303, 8'd0, 8'd0, 1'b1, 1'b1);
    n_vec++;
    if (out_c_w !== 32'h03030303 || out_count_w !== 4'd1) begin
      n_err++;
      $display("FAIL post_reset_group: got c=%h n=%0d want 03030303/1", out_c_w, out_count_w);
    end
    step();
  endtask

  task automatic test_count_saturation();
    for (int k = 0; k < 20; k++) beat(32'h01010101, 8'd0, 8'd0, 1'b1, (k == 19));
    n_vec++;
    if (out_count_w !== 4'd15 || out_c_w !== 32'h14141414) begin
      n_err++;
      $display("FAIL count_sat: got n=%0d c=%h want 15/14141414", out_count_w, out_c_w);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_wrap_vs_sat();
    test_accumulate();
    test_backpressure();
    test_back_to_back();
    test_interleave();
    test_reset_mid_group();
    test_count_saturation();
    step();
    n_vec++;
    if (q_w.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d results never emitted, want 0", q_w.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
